param_sort: RTL
===============

# param_sort

Parametrised, handshaked sorting engine for N unsigned W-bit elements, the next generation of the team's fixed 32×7-bit bubble sorter. It uses odd-even transposition (parallel bubble sort), supports run-time ascending/descending order, terminates early once the array is sorted, and reports the number of phases used. It sits between a producer that presents a packed vector with `start` and a consumer that collects the result and returns `ack`.

## Interface
- `N`, default 32: element count, N ≥ 2 (odd N allowed).
- `W`, default 7: element width in bits, unsigned.
- `CW`, default $clog2(N+1): width of `phase_count`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  request; sampled only in IDLE.
- `ack`  in  1  consumer acknowledge; sampled only in DONE.
- `descending`  in  1  order select; 0 = ascending, 1 = descending; sampled with `start`.
- `data_in`  in  N*W  packed input; element i = `data_in[i*W +: W]`; sampled with `start`.
- `data_out`  out  N*W  packed result, same packing; element 0 is first in the selected order.
- `busy`  out  1  high in SORT.
- `done`  out  1  high in DONE.
- `phase_count`  out  CW  phases executed for the last completed sort.

## Operation
- States: IDLE, SORT, DONE. Reset → IDLE.
- IDLE: if `start`=1, load internal array from `data_in`, latch `descending`, clear phase counter and swap history, go to SORT. Otherwise hold.
- SORT: one phase per cycle, alternating. Phase k even: compare pairs (0,1),(2,3),…; phase k odd: compare pairs (1,2),(3,4),…. All pairs within a phase are compared and swapped in parallel.
- Swap rule: ascending swaps when a[i] > a[i+1]; descending swaps when a[i] < a[i+1]. Equal elements never swap, so the sort is stable and equal values are not counted as swaps.
- Termination at end of phase k, whichever comes first:
  - k ≥ 1 and phases k-1 and k both had zero swaps;
  - k = N-1, i.e. N phases executed, which guarantees a sorted array.
- On termination: copy the array to `data_out`, set `phase_count` = k+1, go to DONE.
- Phases with no pairs (odd phase when N=2) count as zero-swap phases.
- DONE: hold `data_out` and `phase_count`. On `ack`=1, go to IDLE.
- `data_out` and `phase_count` keep their value through IDLE until the next completion. They are never updated mid-sort.
- `start` in SORT or DONE is ignored. `ack` outside DONE is ignored.
- `start` and `ack` both high in DONE: `ack` wins. `start` must be presented again in IDLE.
- Inputs `data_in` and `descending` may change freely after the load cycle.

## Timing
- Reset values: `data_out`=0, `phase_count`=0, `busy`=0, `done`=0, state IDLE, internal array 0.
- Reset mid-SORT or mid-DONE: outputs return to reset values asynchronously. The in-progress result is discarded and nothing is written to `data_out`.
- Start accepted at edge E0 → `busy`=1 from E0.
- Phase j executes at edge E(j+1).
- Completion after P phases: at edge E_P, `busy`=0, `done`=1, and `data_out` and `phase_count` are valid in the same cycle.
- Latency from start edge to `done`: P cycles, where 2 ≤ P ≤ N.
- `ack` sampled high at edge Ea in DONE → `done`=0 from Ea. A new `start` can be accepted at Ea+1 at the earliest.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- N=32, W=7, ascending, `data_in` = {30,22,23,21,13,14,16,12,20,19,28,17,27,24,18,25,26,16,9,11,6,12,31,7,8,10,5,4,3,2,1,0} (element 0 first) → `data_out` = 0,1,…,11,12,12,13,14,16,16,17,…,28,30,31; `done` high until `ack`; 2 ≤ `phase_count` ≤ 32 and equal to the reference-model phase count.
- Same vector with `descending`=1 → `data_out` = 31,30,28,…,17,16,16,14,13,12,12,11,…,0.
- N=8, W=4, already sorted input 0..7 → `done` 2 cycles after start, `phase_count`=2. Reversed input 7..0 → `done` 8 cycles after start, `phase_count`=8, `data_out` = 0..7.
- N=8, all elements = 5 → `phase_count`=2 and output unchanged. Toggle `descending` on the same input → identical result.
- Assert `reset` 3 cycles into a sort of 7..0 → `busy`, `done`, `data_out` and `phase_count` go to 0 immediately. Then start a new sort with 0..7 → completes normally in 2 phases.
- Handshake checks:
  - `start` pulsed during SORT → ignored, no restart.
  - Hold off `ack` for 10 cycles → `done` and `data_out` stable throughout.
  - `start` and `ack` high together in DONE → return to IDLE, no new load.
  - `start` held high continuously → a new sort loads on the cycle after returning to IDLE.

Source files
------------

// File: rtl/param_sort.sv
// param_sort: odd-even transposition sorter for N unsigned W-bit elements.
// Sorts ascending or descending, stops early once two consecutive phases
// make no swap, and reports how many phases the last sort used.
//
// Handshake: `start` is a request that is taken only in IDLE, and it loads
// `data_in` and `descending` on that edge. `done` stays high in DONE until
// `ack` is seen on a rising edge, and that edge returns the block to IDLE.
// A `start` in SORT or DONE is dropped. An `ack` outside DONE is ignored.
// When `start` and `ack` are both high in DONE, `ack` takes priority and
// `start` must be presented again once the block is back in IDLE.
module param_sort #(
    parameter int N  = 32,
    parameter int W  = 7,
    parameter int CW = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            ack,
    input  logic            descending,
    input  logic [N*W-1:0]  data_in,
    output logic [N*W-1:0]  data_out,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   phase_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [W-1:0]   arr    [N];
    logic [W-1:0]   arr_nx [N];
    logic           desc_q;
    logic [CW-1:0]  k;          // index of the phase running this cycle
    logic           prev_zero;  // the previous phase made no swap
    logic           swapped;
    logic           terminate;
    logic [N*W-1:0] packed_nx;

    logic           load;
    logic           advance;
    logic           finish;
    logic           busy_d;
    logic           done_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = SORT;
            SORT:    if (terminate) state_next = DONE;
            DONE:    if (ack)       state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Output and control decode; busy/done are registered from the next state
    always_comb begin
        load    = (state == IDLE) && start;
        advance = (state == SORT);
        finish  = advance && terminate;
        busy_d  = (state_next == SORT);
        done_d  = (state_next == DONE);
    end

    // One compare-exchange phase. Even phases pair (0,1),(2,3)...; odd
    // phases pair (1,2),(3,4)... The pairs are disjoint, so every pair reads
    // the current array and writes its own two slots.
    always_comb begin
        arr_nx  = arr;
        swapped = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            if ((i % 2) == int'(k[0])) begin
                if (desc_q ? (arr[i] < arr[i+1]) : (arr[i] > arr[i+1])) begin
                    arr_nx[i]   = arr[i+1];
                    arr_nx[i+1] = arr[i];
                    swapped     = 1'b1;
                end
            end
        end
    end

    // Stop after two consecutive quiet phases, or after N phases. N phases
    // always sort the array.
    always_comb begin
        terminate = (k == CW'(N - 1)) || ((k != '0) && prev_zero && !swapped);
    end

    // Flatten the post-phase array so it can be captured on completion
    always_comb begin
        packed_nx = '0;
        for (int i = 0; i < N; i++) begin
            packed_nx[i*W +: W] = arr_nx[i];
        end
    end

    // Working array, order latch and phase bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                arr[i] <= '0;
            end
            desc_q    <= 1'b0;
            k         <= '0;
            prev_zero <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < N; i++) begin
                arr[i] <= data_in[i*W +: W];
            end
            desc_q    <= descending;
            k         <= '0;
            prev_zero <= 1'b0;
        end else if (advance) begin
            arr       <= arr_nx;
            k         <= k + CW'(1);
            prev_zero <= !swapped;
        end
    end

    // Registered outputs; the result is only written when a sort completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            data_out    <= '0;
            phase_count <= '0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (finish) begin
                data_out    <= packed_nx;
                phase_count <= k + CW'(1);
            end
        end
    end

endmodule
